// File: rtl/bus_if_pkg.sv
// Shared CPU bus definitions: word widths, bus_if FSM state codes, slave decode, strobe levels.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package bus_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_e;

    // Slave index field of a word address.
    localparam int         BUS_SLAVE_INDEX_MSB = 29;
    localparam int         BUS_SLAVE_INDEX_LSB = 27;
    localparam logic [2:0] BUS_SLAVE_1         = 3'b001;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Slave 1 is the scratch pad, reached without the shared bus.
    function automatic logic is_spm(input word_addr_t a);
        return a[BUS_SLAVE_INDEX_MSB:BUS_SLAVE_INDEX_LSB] == BUS_SLAVE_1;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Initiator-side bus interface for one pipeline stage: SPM accesses go direct, others use req/grant/ready.
// Latency: SPM access 0 wait cycles; bus access 3 cycles minimum (+g grant, +r ready wait cycles).
// Backpressure: busy holds the pipeline until bus ready; stall parks the block in STALL with read data held.
// Ports: clk/reset_ (async, active-low); stall/flush/busy to the pipeline control;
//        addr/as_/rw/wr_data/rd_data from/to the stage; spm_* direct SPM port; bus_* shared bus initiator.
module bus_if
    import bus_if_pkg::*;
(
    input  logic       clk,
    input  logic       reset_,
    input  logic       stall,
    input  logic       flush,
    output logic       busy,
    input  word_addr_t addr,
    input  logic       as_,
    input  logic       rw,
    input  word_data_t wr_data,
    output word_data_t rd_data,
    input  word_data_t spm_rd_data,
    output word_addr_t spm_addr,
    output logic       spm_as_,
    output logic       spm_rw,
    output word_data_t spm_wr_data,
    input  word_data_t bus_rd_data,
    input  logic       bus_rdy_,
    input  logic       bus_grnt_,
    output logic       bus_req_,
    output word_addr_t bus_addr,
    output logic       bus_as_,
    output logic       bus_rw,
    output word_data_t bus_wr_data
);

    bus_if_state_e state, state_nxt;
    logic          bus_req_nxt;
    logic          bus_as_nxt;
    logic          bus_rw_nxt;
    word_addr_t    bus_addr_nxt;
    word_data_t    bus_wr_data_nxt;
    word_data_t    rd_buf, rd_buf_nxt;
    logic          access_vld;
    logic          spm_hit;

    // The SPM sees the stage request unregistered; only its strobe is qualified.
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    assign access_vld = (as_ == ENABLE_) && !flush;
    assign spm_hit    = is_spm(addr);

    always_comb begin
        state_nxt       = state;
        bus_req_nxt     = bus_req_;
        bus_as_nxt      = bus_as_;
        bus_rw_nxt      = bus_rw;
        bus_addr_nxt    = bus_addr;
        bus_wr_data_nxt = bus_wr_data;
        rd_buf_nxt      = rd_buf;
        busy            = 1'b0;
        spm_as_         = DISABLE_;
        rd_data         = '0;

        case (state)
            BUS_IF_STATE_IDLE: begin
                if (access_vld) begin
                    if (spm_hit) begin
                        // A stalled SPM write simply repeats; the SPM tolerates it.
                        spm_as_ = ENABLE_;
                        rd_data = spm_rd_data;
                    end else begin
                        busy            = 1'b1;
                        bus_req_nxt     = ENABLE_;
                        bus_addr_nxt    = addr;
                        bus_rw_nxt      = rw;
                        bus_wr_data_nxt = wr_data;
                        state_nxt       = BUS_IF_STATE_REQ;
                    end
                end
            end
            BUS_IF_STATE_REQ: begin
                // flush/stall are ignored here: a started transaction always completes.
                busy = 1'b1;
                if (bus_grnt_ == ENABLE_) begin
                    bus_as_nxt = ENABLE_;
                    state_nxt  = BUS_IF_STATE_ACCESS;
                end
            end
            BUS_IF_STATE_ACCESS: begin
                // Strobe is a single-cycle pulse on entry.
                bus_as_nxt = DISABLE_;
                if (bus_rdy_ == ENABLE_) begin
                    bus_req_nxt     = DISABLE_;
                    bus_addr_nxt    = '0;
                    bus_rw_nxt      = READ;
                    bus_wr_data_nxt = '0;
                    if (bus_rw == READ) begin
                        rd_buf_nxt = bus_rd_data;
                    end
                    // Bypass so the pipeline can advance on this very edge.
                    rd_data   = bus_rd_data;
                    state_nxt = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            BUS_IF_STATE_STALL: begin
                // Pipeline is frozen by the controller; keep presenting the captured data.
                rd_data = rd_buf;
                if (!stall) begin
                    state_nxt = BUS_IF_STATE_IDLE;
                end
            end
            default: begin
                state_nxt = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= BUS_IF_STATE_IDLE;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            state       <= state_nxt;
            bus_req_    <= bus_req_nxt;
            bus_as_     <= bus_as_nxt;
            bus_addr    <= bus_addr_nxt;
            bus_rw      <= bus_rw_nxt;
            bus_wr_data <= bus_wr_data_nxt;
            rd_buf      <= rd_buf_nxt;
        end
    end

endmodule
